// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; divider present only with MDU_DIV_EN
module mdu_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        rd_hilo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_m;
    logic [31:0]    r_acc;
    logic [31:0]    r_q;
    logic           r_div;
    logic           r_neg_q;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;
    logic           r_busy;
    logic           r_done;

    logic           w_signed;
    logic [31:0]    w_a_mag;
    logic [31:0]    w_b_mag;
    logic [32:0]    w_mul_sum;
    logic [63:0]    w_prod;
    logic [63:0]    w_prod_fix;
    logic [31:0]    w_acc_nxt;
    logic [31:0]    w_q_nxt;
    logic [31:0]    w_hi_res;
    logic [31:0]    w_lo_res;
    logic           w_wr_res;

    assign w_signed = ~op[0];
    assign w_a_mag  = (w_signed && A[31]) ? (32'd0 - A) : A;
    assign w_b_mag  = (w_signed && B[31]) ? (32'd0 - B) : B;

    // Multiply keeps the running high word in r_acc and shifts product bits into r_q.
    assign w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : 33'd0);
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;

`ifdef MDU_DIV_EN
    logic           r_neg_r;
    logic           r_divz;
    logic           w_div_ge;
    logic [31:0]    w_div_rem;
    logic [31:0]    w_quo_fix;
    logic [31:0]    w_rem_fix;

    // The partial remainder is always below the divisor, so the 32-bit difference is exact when it fits.
    assign w_div_ge  = {r_acc, r_q[31]} >= {1'b0, r_m};
    assign w_div_rem = {r_acc[30:0], r_q[31]} - r_m;
    assign w_quo_fix = (r_neg_q && !r_divz) ? (32'd0 - r_q) : r_q;
    assign w_rem_fix = r_neg_r ? (32'd0 - r_acc) : r_acc;
`endif

    always_comb begin
        w_acc_nxt = w_mul_sum[32:1];
        w_q_nxt   = {w_mul_sum[0], r_q[31:1]};
        w_hi_res  = w_prod_fix[63:32];
        w_lo_res  = w_prod_fix[31:0];
        w_wr_res  = 1'b1;
        if (r_div) begin
`ifdef MDU_DIV_EN
            if (w_div_ge) begin
                w_acc_nxt = w_div_rem;
                w_q_nxt   = {r_q[30:0], 1'b1};
            end else begin
                w_acc_nxt = {r_acc[30:0], r_q[31]};
                w_q_nxt   = {r_q[30:0], 1'b0};
            end
            w_hi_res = w_rem_fix;
            w_lo_res = w_quo_fix;
`else
            w_acc_nxt = r_acc;
            w_q_nxt   = r_q;
            w_wr_res  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MDU_DIV_EN
            r_neg_r <= 1'b0;
            r_divz  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (mthi) r_hi <= A;
                if (mtlo) r_lo <= A;
            end
            if (cancel) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_count <= '0;
                            r_acc   <= '0;
                            r_div   <= op[1];
                            r_neg_q <= w_signed & (A[31] ^ B[31]);
                            // Divide shifts the dividend out of r_q; multiply shifts the multiplier out.
                            r_m     <= op[1] ? w_b_mag : w_a_mag;
                            r_q     <= op[1] ? w_a_mag : w_b_mag;
`ifdef MDU_DIV_EN
                            r_neg_r <= w_signed & A[31];
                            r_divz  <= op[1] & (B == 32'd0);
`endif
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_CALC: begin
                        r_acc   <= w_acc_nxt;
                        r_q     <= w_q_nxt;
                        r_count <= r_count + CW'(1);
                        if (r_count == CW'(ITER - 1))
                            r_state <= S_FIX;
                    end
                    S_FIX: begin
                        if (w_wr_res) begin
                            r_hi <= w_hi_res;
                            r_lo <= w_lo_res;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = r_busy;
    assign done  = r_done;
    assign stall = r_busy & (start | mthi | mtlo | rd_hilo);
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed bench for mdu_ctrl; divide expectations follow MDU_DIV_EN
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, cancel, mthi, mtlo, rd_hilo;
    logic [1:0]  op;
    logic [31:0] A, B, hi, lo;
    logic        busy, done, stall;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;
    logic [31:0] e_hi, e_lo;

    mdu_ctrl #(.ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .rd_hilo(rd_hilo),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Launches and returns the number of busy cycles; leaves time in the first non-busy cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc);
        launch(o, a, b);
        busy_cyc = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            busy_cyc++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; cancel = 0; mthi = 0; mtlo = 0; rd_hilo = 0;
        op = 2'd0; A = 0; B = 0;
        tick(2);
        rst = 1'b0;
        rd_hilo = 1'b1; #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);
        rd_hilo = 1'b0;

        run_op(2'd0, 32'hFFFFFFFD, 32'd7, cnt);
        chk("mult_busy_cycles", cnt, 33);
        chk("mult_done", {31'd0, done}, 32'd1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        tick();
        chk("mult_done_once", {31'd0, done}, 32'd0);

        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, cnt);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        e_hi = 32'hFFFFFFFE; e_lo = 32'h00000001;

        run_op(2'd2, 32'hFFFFFFF9, 32'd2, cnt);
        chk("div_busy_cycles", cnt, 33);
        chk("div_done", {31'd0, done}, 32'd1);
`ifdef MDU_DIV_EN
        e_hi = 32'hFFFFFFFF; e_lo = 32'hFFFFFFFD;
`endif
        chk("div_hi", hi, e_hi);
        chk("div_lo", lo, e_lo);

        run_op(2'd3, 32'd5, 32'd0, cnt);
`ifdef MDU_DIV_EN
        e_hi = 32'd5; e_lo = 32'hFFFFFFFF;
`endif
        chk("divu_zero_hi", hi, e_hi);
        chk("divu_zero_lo", lo, e_lo);

        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, cnt);
`ifdef MDU_DIV_EN
        e_hi = 32'd0; e_lo = 32'h80000000;
`endif
        chk("div_ovf_hi", hi, e_hi);
        chk("div_ovf_lo", lo, e_lo);
        chk("div_ovf_done", {31'd0, done}, 32'd1);

        // MFLO stalled from cycle 5 of a 6*7 multiply
        launch(2'd0, 32'd6, 32'd7);
        tick(4);
        rd_hilo = 1'b1; #1;
        cnt = 0;
        for (int i = 0; i < 29; i++) begin
            if (stall === 1'b1) cnt++;
            tick();
        end
        chk("rd_stall_cycles", cnt, 29);
        chk("rd_stall_c34", {31'd0, stall}, 32'd0);
        chk("rd_lo_c34", lo, 32'd42);
        rd_hilo = 1'b0;

        launch(2'd1, 32'd2, 32'd3);
        tick(9);
        mtlo = 1'b1; A = 32'h1234; #1;
        chk("mtlo_stall", {31'd0, stall}, 32'd1);
        tick();
        mtlo = 1'b0;
        chk("mtlo_blocked", lo, 32'd42);
        tick(23);
        chk("mtlo_op_done", {31'd0, done}, 32'd1);
        chk("mtlo_op_lo", lo, 32'd6);

        launch(2'd0, 32'd10, 32'hFFFFFFFE);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            cnt++;
            tick();
        end
        chk("b2b_busy_cycles", cnt, 33);
        chk("b2b_hi", hi, 32'hFFFFFFFF);
        chk("b2b_lo", lo, 32'hFFFFFFEC);
        mtlo = 1'b1; A = 32'h55;
        tick();
        mtlo = 1'b0;
        chk("done_mtlo_lo", lo, 32'h55);
        chk("done_mtlo_hi", hi, 32'hFFFFFFFF);

        launch(2'd3, 32'd100, 32'd7);
        tick(19);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) cnt++;
            tick();
        end
        chk("cancel_no_done", cnt, 0);
        chk("cancel_hi", hi, 32'hFFFFFFFF);
        chk("cancel_lo", lo, 32'h55);

        start = 1'b1; cancel = 1'b1; op = 2'd0; A = 32'd3; B = 32'd3;
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("cancel_start_busy", {31'd0, busy}, 32'd0);

        launch(2'd0, 32'd3, 32'd3);
        tick(19);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        mthi = 1'b1; A = 32'hCAFEF00D;
        tick();
        mthi = 1'b0;
        chk("idle_mthi", hi, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
